// File: rtl/ifft_pkg.sv
// Shared IFFT datapath definitions: widths, stage address base, sample type, round/narrow helper.
// Build option IFFT_TWM_SAT_EN: saturate on narrowing instead of two's-complement wrap.
package ifft_pkg;

    localparam int DW        = 16;
    localparam int TW_FRAC   = 8;
    localparam int AW        = 5;
    localparam int MAX_STAGE = 4;
    localparam int SW        = 3;
    localparam int TWW       = 16;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } sample_t;

    // Twiddles for stage s occupy the block starting at 2^s - 1.
    function automatic logic [AW-1:0] base(input logic [SW-1:0] s);
        logic [AW:0] v_pow;
        v_pow = (AW+1)'(1) << s;
        base  = AW'(v_pow - (AW+1)'(1));
    endfunction

    // Round half-up, drop TW_FRAC fraction bits, then narrow to DW.
    function automatic logic signed [DW-1:0] round_narrow(input logic signed [2*DW:0] v);
        localparam logic signed [2*DW:0] RND     = (2*DW+1)'(1) <<< (TW_FRAC-1);
        localparam logic signed [2*DW:0] SAT_MAX = (2*DW+1)'((1 << (DW-1)) - 1);
        localparam logic signed [2*DW:0] SAT_MIN = ~SAT_MAX;
        logic signed [2*DW:0] v_sh;
        v_sh = (v + RND) >>> TW_FRAC;
`ifdef IFFT_TWM_SAT_EN
        if (v_sh > SAT_MAX)
            round_narrow = SAT_MAX[DW-1:0];
        else if (v_sh < SAT_MIN)
            round_narrow = SAT_MIN[DW-1:0];
        else
            round_narrow = v_sh[DW-1:0];
`else
        round_narrow = v_sh[DW-1:0];
`endif
    endfunction

endpackage

// File: rtl/ifft_cmul_pipe.sv
// Back half of the twiddle multiplier: registered partial products, then complex sum,
// rounding and narrowing into the output register. Every stage advances only on i_en.
module ifft_cmul_pipe
    import ifft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  sample_t               i_smp,
    input  logic signed [TWW-1:0] i_wr,
    input  logic signed [TWW-1:0] i_wi,
    output logic                  o_valid,
    output logic signed [DW-1:0]  o_re,
    output logic signed [DW-1:0]  o_im
);

    localparam int PW = 2*DW;

    logic signed [PW-1:0] w_re_x;
    logic signed [PW-1:0] w_im_x;
    logic signed [PW-1:0] w_wr_x;
    logic signed [PW-1:0] w_wi_x;
    logic signed [PW:0]   w_pr;
    logic signed [PW:0]   w_pi;

    logic                 r_p3_valid;
    logic signed [PW-1:0] r_rr;
    logic signed [PW-1:0] r_ii;
    logic signed [PW-1:0] r_ri;
    logic signed [PW-1:0] r_ir;

    assign w_re_x = PW'($signed(i_smp.re));
    assign w_im_x = PW'($signed(i_smp.im));
    assign w_wr_x = PW'(i_wr);
    assign w_wi_x = PW'(i_wi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p3_valid <= 1'b0;
            r_rr       <= '0;
            r_ii       <= '0;
            r_ri       <= '0;
            r_ir       <= '0;
        end else if (i_en) begin
            r_p3_valid <= i_valid;
            r_rr       <= w_re_x * w_wr_x;
            r_ii       <= w_im_x * w_wi_x;
            r_ri       <= w_re_x * w_wi_x;
            r_ir       <= w_im_x * w_wr_x;
        end
    end

    // One extra bit so the sum of two full-scale products cannot overflow.
    assign w_pr = (PW+1)'(r_rr) - (PW+1)'(r_ii);
    assign w_pi = (PW+1)'(r_ri) + (PW+1)'(r_ir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
        end else if (i_en) begin
            o_valid <= r_p3_valid;
            o_re    <= round_narrow(w_pr);
            o_im    <= round_narrow(w_pi);
        end
    end

endmodule

// File: rtl/ifft_twiddle_mult.sv
// Pipelined IFFT twiddle multiplier: twiddle addressing, ROM alignment and handshake.
// Build option IFFT_TWM_SAT_EN (in ifft_pkg::round_narrow) selects saturating narrowing.
module ifft_twiddle_mult
    import ifft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic [SW-1:0]         in_stage,
    input  logic signed [DW-1:0]  in_re,
    input  logic signed [DW-1:0]  in_im,
    output logic [AW-1:0]         rom_addr,
    input  logic [TWW-1:0]        rom_re_data,
    input  logic [TWW-1:0]        rom_im_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [DW-1:0]  out_re,
    output logic signed [DW-1:0]  out_im,
    output logic                  stage_err
);

    logic          w_en;
    logic          w_accept;
    logic          w_stage_ok;
    logic [AW-1:0] w_k_use;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_addr;

    logic          r_k_unused_guard;
    logic [AW-1:0] r_k;

    logic          r_p1_valid;
    sample_t       r_p1_smp;
    logic          r_p2_valid;
    sample_t       r_p2_smp;
    logic signed [TWW-1:0] r_wr;
    logic signed [TWW-1:0] r_wi;

    assign w_en       = !out_valid || out_ready;
    assign in_ready   = w_en;
    assign w_accept   = in_valid && w_en;
    assign w_stage_ok = (in_stage <= SW'(MAX_STAGE));
    assign w_k_use    = in_first ? '0 : r_k;
    assign w_base     = base(in_stage);
    // Illegal stages point at entry 0 (twiddle 1.0) so the sample passes through unrotated.
    assign w_addr     = w_stage_ok ? (w_base + (w_k_use & w_base)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k       <= '0;
            rom_addr  <= '0;
            stage_err <= 1'b0;
        end else if (w_accept) begin
            r_k      <= w_k_use + AW'(1);
            rom_addr <= w_addr;
            if (!w_stage_ok)
                stage_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_k_unused_guard <= 1'b0;
        else
            r_k_unused_guard <= 1'b0;
    end

    // rom_addr holds during a stall, so the ROM output stays matched to r_p1_smp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_smp   <= '0;
            r_p2_valid <= 1'b0;
            r_p2_smp   <= '0;
            r_wr       <= '0;
            r_wi       <= '0;
        end else if (w_en) begin
            r_p1_valid <= w_accept;
            r_p1_smp   <= '{re: in_re, im: in_im};
            r_p2_valid <= r_p1_valid;
            r_p2_smp   <= r_p1_smp;
            r_wr       <= rom_re_data;
            r_wi       <= rom_im_data;
        end
    end

    ifft_cmul_pipe u_cmul (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (r_p2_valid),
        .i_smp   (r_p2_smp),
        .i_wr    (r_wr),
        .i_wi    (r_wi),
        .o_valid (out_valid),
        .o_re    (out_re),
        .o_im    (out_im)
    );

endmodule

// File: tb/tb_ifft_twiddle_mult.sv
// Scoreboard bench for ifft_twiddle_mult: directed samples push hand-computed products,
// a monitor pops and compares on every output handshake.
module tb_ifft_twiddle_mult;
    import ifft_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_first;
    logic [2:0]           in_stage;
    logic signed [15:0]   in_re;
    logic signed [15:0]   in_im;
    logic [4:0]           rom_addr;
    logic [15:0]          rom_re_data;
    logic [15:0]          rom_im_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [15:0]   out_re;
    logic signed [15:0]   out_im;
    logic                 stage_err;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];
    int          sat_im;
    int          held_addr;
    int          held_re;
    int          held_im;
    int          n_wait;

    always #5 clk = ~clk;

    // Twiddle ROM: address is the DUT's registered rom_addr, data visible the following cycle.
    assign rom_re_data = rom_re[rom_addr];
    assign rom_im_data = rom_im[rom_addr];

    ifft_twiddle_mult dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_stage    (in_stage),
        .in_re       (in_re),
        .in_im       (in_im),
        .rom_addr    (rom_addr),
        .rom_re_data (rom_re_data),
        .rom_im_data (rom_im_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .stage_err   (stage_err)
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got re=%0d im=%0d expected no output", out_re, out_im);
            end else begin
                mon_e = q.pop_front();
                chk("out_re", out_re, mon_e.re);
                chk("out_im", out_im, mon_e.im);
            end
        end
    end

    task automatic send(input logic first, input logic [2:0] stage, input int re, input int im,
                        input int exp_addr, input int exp_re, input int exp_im);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_first = first;
        in_stage = stage;
        in_re    = 16'(re);
        in_im    = 16'(im);
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        q.push_back('{re: 16'(exp_re), im: 16'(exp_im)});
        @(posedge clk);
        #1;
        chk("rom_addr", rom_addr, exp_addr);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = 16'h0100;
            rom_im[i] = 16'h0000;
        end
        rom_re[1] = 16'h0000; rom_im[1] = 16'h0100;
        rom_re[2] = 16'h0100; rom_im[2] = 16'h0100;
        rom_re[3] = 16'h00B5; rom_im[3] = 16'h00B5;
`ifdef IFFT_TWM_SAT_EN
        sat_im = 32767;
`else
        sat_im = -2;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_stage  = 3'd0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_stage_err", stage_err, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Identity twiddle plus exact 4-edge latency.
        send(1'b1, 3'd0, 1000, -2000, 0, 1000, -2000);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat3_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat4_out_valid", out_valid, 1);

        // Rotation by j, saturation/wrap, rounding.
        send(1'b1, 3'd1, 300, 500, 1, -500, 300);
        send(1'b0, 3'd1, 32767, 32767, 2, 0, sat_im);
        send(1'b1, 3'd2, 1, 1, 3, 0, 1);

        // Address walk in stage 3, then stage 4 up to k=31 and the wrap to 0.
        for (int i = 0; i < 10; i++)
            send(i == 0, 3'd3, 50*i - 200, 17*i + 3, 7 + (i % 8), 50*i - 200, 17*i + 3);
        for (int k = 10; k < 32; k++)
            send(1'b0, 3'd4, k*9 - 100, 200 - k*11, 15 + (k % 16), k*9 - 100, 200 - k*11);
        send(1'b0, 3'd4, 77, -77, 15, 77, -77);

        // Illegal stage: address 0, sticky error, sample still flows.
        send(1'b0, 3'd6, 1234, -4321, 0, 1234, -4321);
        chk("stage_err_set", stage_err, 1);
        send(1'b0, 3'd0, 5, 6, 0, 5, 6);
        chk("stage_err_sticky", stage_err, 1);
        idle();
        repeat (6) @(negedge clk);

        // Backpressure: out_ready low for 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i == 0, 3'd0, 100*i + 7, -50*i - 3, 0, 100*i + 7, -50*i - 3);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                #2;
                held_addr = rom_addr;
                held_re   = out_re;
                held_im   = out_im;
                chk("stall_in_ready0", in_ready, 0);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_rom_addr", rom_addr, held_addr);
                    chk("stall_out_re", out_re, held_re);
                    chk("stall_out_im", out_im, held_im);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);

        // Reset mid-stream discards the pipeline and restarts k at 0.
        for (int i = 0; i < 6; i++)
            send(i == 0, 3'd3, i + 40, -i - 40, 7 + i, i + 40, -i - 40);
        send(1'b0, 3'd7, 9, 9, 0, 9, 9);
        chk("pre_rst_stage_err", stage_err, 1);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_stage_err", stage_err, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(1'b0, 3'd3, 321, -123, 7, 321, -123);
        send(1'b0, 3'd3, 11, 22, 8, 11, 22);
        idle();

        n_wait = 0;
        while (q.size() != 0 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifft_twiddle_mult.md
Name: ifft_twiddle_mult

Overview:
- Pipelined complex twiddle multiplier for the IFFT butterfly datapath.
- Consumes the butterfly's lower-leg sample stream and generates the 5-bit twiddle address for the paired real and imaginary twiddle ROMs.
- Aligns the ROMs' 1-cycle registered read with the sample, and outputs the rounded Q8 complex product to the next butterfly stage.

Parameters:
- DW, 16, signed sample width for each of re and im.
- TW_FRAC, 8, twiddle fraction bits; 16'h0100 = +1.0.
- AW, 5, twiddle ROM address width.
- MAX_STAGE, 4, highest legal stage index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_first  in  1  first sample of a stage pass; clears the index counter
- in_stage  in  3  butterfly stage index, 0..MAX_STAGE
- in_re  in  DW  sample real part, signed
- in_im  in  DW  sample imaginary part, signed
- rom_addr  out  AW  address to both twiddle ROMs; registered
- rom_re_data  in  16  real twiddle; valid 1 cycle after rom_addr
- rom_im_data  in  16  imaginary twiddle; valid 1 cycle after rom_addr
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts the product
- out_re  out  DW  product real part
- out_im  out  DW  product imaginary part
- stage_err  out  1  sticky flag: in_stage > MAX_STAGE was seen

Behaviour:
- Reset values (async, on rst high): all of the following are 0:
  - rom_addr, the index counter k, out_valid, out_re, out_im, stage_err
  - every pipeline valid bit and data register
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational.
- Accept: a sample is taken when in_valid && in_ready.
- Index counter k (5 bits), per accepted sample:
  - in_first=1: the sample uses k=0, and k becomes 1.
  - otherwise: the sample uses the current k, and k increments, wrapping 31->0.
- Address, registered into rom_addr on accept: rom_addr = (2^s - 1) + (k & (2^s - 1)), where s = in_stage.
  - Example: s=3, k=5 gives 7+5 = 12.
  - Illegal stage (s > MAX_STAGE): rom_addr = 0 (twiddle 1.0 expected), stage_err is set and stays set until reset, and the sample still flows.
- Pipeline, all registers gated by en:
  - P1 (edge of accept): latch sample, valid bit and rom_addr.
  - P2: ROM data is now available; latch sample and the twiddle (wr, wi).
  - P3: register four products: re*wr, im*wi, re*wi, im*wr. Each is signed 32-bit.
  - P4: pr = re*wr - im*wi, pi = re*wi + im*wr (33-bit sums), then round and narrow:
    - Round half-up: add 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC.
    - Narrow to DW as defined under Optional Feature. Register into out_re/out_im and set out_valid.
- Latency: 4 clk edges from accept to out_valid, with no stalls. Throughput: 1 sample/cycle.
- Stall (out_valid && !out_ready):
  - All stages hold, including rom_addr.
  - The ROM keeps re-reading the same address, so the twiddle stays aligned.
  - out_re/out_im are stable.
- Bubbles: invalid slots advance as valid=0. Data registers may update, but out_valid=0.
- Simultaneous accept and output handshake in the same cycle: both proceed.
- rst asserted mid-frame: pipeline contents are discarded and k returns to 0.

Optional Feature:
- Macro: IFFT_TWM_SAT_EN.
- Defined: the narrowed result saturates to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: the narrowed result is truncated to the low DW bits (two's-complement wrap).
- Latency is identical in both builds.

Decomposition:
- Shared package ifft_pkg holds:
  - DW, TW_FRAC, AW, MAX_STAGE
  - the stage base function base(s) = 2^s - 1
  - a sample_t struct {re, im}
  - a round_shift/saturate function shared with the butterfly
- One natural sub-module: ifft_cmul_pipe, covering P3–P4 (products, sum, round, narrow) with an enable input.
- Addressing and the handshake stay in the top level.

Test Plan:
- Identity: s=0, in_first=1, sample (1000, -2000), ROM returns wr=0x0100, wi=0 -> rom_addr=0, then 4 cycles later out=(1000, -2000).
- Address walk: s=3, 10 samples with in_first on the first -> rom_addr sequence 7,8,…,14,7,8; k=31 followed by a further sample wraps to 0.
- Rotation: wr=0, wi=0x0100, sample (300, 500) -> out=(-500, 300). Rounding case: wr=wi=0x00B5, sample (1, 1) -> re=0, im=round(362/256)=1.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream of 8 samples -> in_ready=0 while out_valid=1, rom_addr stable, no samples lost or duplicated, outputs in order.
- Saturation: sample (32767, 32767), wr=wi=0x0100 -> im: 65534>>0 → with IFFT_TWM_SAT_EN out_im=32767, without it out_im=-2 (wrapped).
- Illegal stage and reset: in_stage=6 -> rom_addr=0 and stage_err=1 (sticky); asserting rst mid-stream clears out_valid and stage_err immediately, and the next sample uses k=0.
